// File: rtl/riscv_branch_predictor.sv
// riscv_branch_predictor: direct-mapped BTB plus a table of 2-bit saturating
// counters. Fetch gets a same-cycle prediction; execute trains both tables.
// Optional gshare indexing of the counter table: define RISCV_BP_GSHARE_EN.

package riscv_types_pkg;
  typedef logic [31:0] addr_t;

  typedef struct packed {
    logic  predict_taken;
    addr_t predict_target;
    logic  btb_hit;
  } branch_prediction_t;

  typedef struct packed {
    logic  update_valid;
    addr_t update_pc;
    logic  actual_taken;
    addr_t actual_target;
    logic  is_branch;
  } branch_update_t;
endpackage

module riscv_branch_predictor
  import riscv_types_pkg::*;
#(
  parameter int BTB_ENTRIES = 64,
  parameter int PHT_ENTRIES = 256,
  parameter int GHR_W       = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               fetch_valid_i,
  input  addr_t              fetch_pc_i,
  output branch_prediction_t prediction_o,
  input  branch_update_t     update_i
);

  localparam int IDX_W  = $clog2(BTB_ENTRIES);
  localparam int PIDX_W = $clog2(PHT_ENTRIES);
  localparam int TAG_W  = 30 - IDX_W;

  // History must fit inside the counter index it is folded into.
  if (GHR_W > PIDX_W) begin : g_bad_ghr
    $error("GHR_W must not exceed log2(PHT_ENTRIES)");
  end

  logic             btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
  addr_t            btb_target [BTB_ENTRIES];
  logic [1:0]       pht        [PHT_ENTRIES];

  logic [IDX_W-1:0]  f_idx, u_idx;
  logic [TAG_W-1:0]  f_tag, u_tag;
  logic [PIDX_W-1:0] f_pidx, u_pidx;
  logic [1:0]        ctr_next;
  logic              update_en, btb_write;

  // The two low PC bits never select anything.
  logic unused_pc_bits;
  assign unused_pc_bits = ^update_i.update_pc[1:0];

  assign f_idx = fetch_pc_i[IDX_W+1:2];
  assign f_tag = fetch_pc_i[31:IDX_W+2];
  assign u_idx = update_i.update_pc[IDX_W+1:2];
  assign u_tag = update_i.update_pc[31:IDX_W+2];

  assign update_en = rst_ni && update_i.update_valid;
  assign btb_write = update_en && (update_i.actual_taken || !update_i.is_branch);

`ifdef RISCV_BP_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  // Non-speculative global history, shifted by resolved conditional branches.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ghr <= '0;
    end else if (update_i.update_valid && update_i.is_branch) begin
      ghr <= {ghr[GHR_W-2:0], update_i.actual_taken};
    end
  end

  assign f_pidx = fetch_pc_i[PIDX_W+1:2] ^ PIDX_W'(ghr);
  assign u_pidx = update_i.update_pc[PIDX_W+1:2] ^ PIDX_W'(ghr);
`else
  assign f_pidx = fetch_pc_i[PIDX_W+1:2];
  assign u_pidx = update_i.update_pc[PIDX_W+1:2];
`endif

  // Lookup: zero-latency read of the registered tables, no update bypass.
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch is inferred on any path.
  always_comb begin
    prediction_o = '0;
    if (rst_ni && fetch_valid_i) begin
      prediction_o.btb_hit       = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
      prediction_o.predict_taken = prediction_o.btb_hit && pht[f_pidx][1];
      prediction_o.predict_target = prediction_o.predict_taken ? btb_target[f_idx]
                                                               : fetch_pc_i + 32'd4;
    end
  end

  // Counter training: saturating step for branches, force strongly-taken for jumps.
  always_comb begin
    ctr_next = pht[u_pidx];
    if (!update_i.is_branch) begin
      ctr_next = 2'b11;
    end else if (update_i.actual_taken) begin
      if (pht[u_pidx] != 2'b11) ctr_next = pht[u_pidx] + 2'd1;
    end else begin
      if (pht[u_pidx] != 2'b00) ctr_next = pht[u_pidx] - 2'd1;
    end
  end

  // Control state: valid bits and counters, cleared by reset.
  // NOTE: sequential state uses non-blocking '<=' so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= 2'b01;
    end else if (update_i.update_valid) begin
      if (btb_write) btb_valid[u_idx] <= 1'b1;
      pht[u_pidx] <= ctr_next;
    end
  end

  // BTB payload: tag and target are written on allocation only.
  // NOTE: payload arrays are deliberately not reset; the valid bit guards
  // them, which keeps them plain RAM without a reset fan-out.
  always_ff @(posedge clk_i) begin
    if (btb_write) begin
      btb_tag[u_idx]    <= u_tag;
      btb_target[u_idx] <= update_i.actual_target;
    end
  end

endmodule

// File: tb/tb_riscv_branch_predictor.sv
// Directed self-checking bench for riscv_branch_predictor (default build).
module tb_riscv_branch_predictor;
  import riscv_types_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               fetch_valid;
  addr_t              fetch_pc;
  branch_prediction_t prediction;
  branch_update_t     update;

  int n_checks = 0;
  int n_errors = 0;

  riscv_branch_predictor dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .fetch_valid_i (fetch_valid),
    .fetch_pc_i    (fetch_pc),
    .prediction_o  (prediction),
    .update_i      (update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [33:0] observed, input logic [33:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Present a lookup mid-cycle and compare all three prediction fields.
  task automatic lookup(input string tag, input addr_t pc, input logic exp_hit,
                        input logic exp_taken, input addr_t exp_target);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    #1;
    check({tag, ".hit"},    34'(prediction.btb_hit),        34'(exp_hit));
    check({tag, ".taken"},  34'(prediction.predict_taken),  34'(exp_taken));
    check({tag, ".target"}, 34'(prediction.predict_target), 34'(exp_target));
  endtask

  // Hold an update across exactly one rising edge, then withdraw it.
  task automatic apply(input logic valid, input addr_t pc, input logic taken,
                       input addr_t target, input logic is_branch);
    update = '{update_valid: valid, update_pc: pc, actual_taken: taken,
               actual_target: target, is_branch: is_branch};
    @(posedge clk);
    #1;
    update = '0;
  endtask

  initial begin
    rst_n       = 1'b0;
    fetch_valid = 1'b0;
    fetch_pc    = '0;
    update      = '0;

    // Reset: output forced to zero, and an update during reset is dropped.
    @(negedge clk);
    fetch_valid = 1'b1;
    fetch_pc    = 32'h100;
    #1;
    check("reset_output", prediction, 34'h0);
    apply(1'b1, 32'h100, 1'b1, 32'h500, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    lookup("cold_0x100", 32'h100, 1'b0, 1'b0, 32'h104);
    fetch_valid = 1'b0;
    #1;
    check("fetch_invalid", prediction, 34'h0);

    // First taken branch: same cycle sees old contents, next cycle hits.
    fetch_valid = 1'b1;
    fetch_pc    = 32'h100;
    update = '{update_valid: 1'b1, update_pc: 32'h100, actual_taken: 1'b1,
               actual_target: 32'h200, is_branch: 1'b1};
    #1;
    check("no_bypass_hit", 34'(prediction.btb_hit), 34'h0);
    @(posedge clk);
    #1;
    update = '0;
    lookup("trained", 32'h100, 1'b1, 1'b1, 32'h200);

    // Saturate high, then step down.
    repeat (3) apply(1'b1, 32'h100, 1'b1, 32'h200, 1'b1);
    apply(1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    lookup("sat3_nt1", 32'h100, 1'b1, 1'b1, 32'h200);
    apply(1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    lookup("sat3_nt2", 32'h100, 1'b1, 1'b0, 32'h104);

    // Invalid updates change nothing.
    repeat (2) apply(1'b0, 32'h100, 1'b1, 32'h999, 1'b1);
    lookup("invalid_upd", 32'h100, 1'b1, 1'b0, 32'h104);

    // Saturate low: after 3 more not-taken, one taken must stay not-taken.
    repeat (3) apply(1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    apply(1'b1, 32'h100, 1'b1, 32'h200, 1'b1);
    lookup("sat0_t1", 32'h100, 1'b1, 1'b0, 32'h104);
    apply(1'b1, 32'h100, 1'b1, 32'h200, 1'b1);
    lookup("sat0_t2", 32'h100, 1'b1, 1'b1, 32'h200);

    // Not-taken branch on a miss does not allocate.
    apply(1'b1, 32'h104, 1'b0, 32'h700, 1'b1);
    lookup("nt_no_alloc", 32'h104, 1'b0, 1'b0, 32'h108);

    // Alias into BTB index 0.
    apply(1'b1, 32'h200, 1'b1, 32'h300, 1'b1);
    lookup("alias_evicted", 32'h100, 1'b0, 1'b0, 32'h104);
    lookup("alias_new", 32'h200, 1'b1, 1'b1, 32'h300);

    // Jump with a same-cycle lookup of the same PC.
    fetch_pc = 32'h400;
    update = '{update_valid: 1'b1, update_pc: 32'h400, actual_taken: 1'b1,
               actual_target: 32'h80, is_branch: 1'b0};
    #1;
    check("jump_same_cycle_hit", 34'(prediction.btb_hit), 34'h0);
    check("jump_same_cycle_tgt", 34'(prediction.predict_target), 34'h404);
    @(posedge clk);
    #1;
    update = '0;
    lookup("jump_next", 32'h400, 1'b1, 1'b1, 32'h80);

    // Fall-through wraps modulo 2^32.
    lookup("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
